// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative unsigned multiply/divide unit feeding the register file write port.
module muldiv_unit #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [REG_BITS-1:0] rd_in,
  output logic                busy,
  output logic                done,
  output logic                wb_en,
  output logic [REG_BITS-1:0] wb_reg,
  output logic [WIDTH-1:0]    result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_hi, r_lo, r_b, r_result;
  logic [1:0]           r_op;
  logic [CW-1:0]        r_cnt;
  logic [REG_BITS-1:0]  r_wb_reg;
  logic [WIDTH:0]       w_sum, w_sh;
  logic [WIDTH-1:0]     w_diff, w_hi, w_lo;
  logic                 w_ge, w_last, w_accept;

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next   = r_state;
    w_last   = r_cnt == CW'(WIDTH-1);
    w_accept = r_state == IDLE && start;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end

  // hi:lo is the product (shift-add) or remainder:quotient (restoring divide)
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_ge   = w_sh >= {1'b0, r_b};
    w_diff = w_sh[WIDTH-1:0] - r_b;
    w_hi   = r_op[1] ? (w_ge ? w_diff : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
    w_lo   = r_op[1] ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_wb_reg <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_hi     <= '0;
      r_lo     <= a;
      r_b      <= b;
      r_op     <= op;
      r_cnt    <= '0;
      r_wb_reg <= rd_in;
    end else if (r_state == RUN) begin
      r_hi  <= w_hi;
      r_lo  <= w_lo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= r_op[0] ? w_hi : w_lo;
    end

  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
  assign wb_en  = done;
  assign wb_reg = r_wb_reg;
  assign result = r_result;
endmodule
